decode_operand_unit: RTL and testbench
======================================

# decode_operand_unit

Parametrised decode-stage operand unit: register file with write-through bypass, three-level forwarding mux, per-register in-flight write scoreboard with hazard stall, and a valid/ready output pipeline register feeding execute. Generalises the fixed 8×16 decode register read to configurable width and depth. Adds what the fixed version lacks: multiple outstanding writers per register, load-use stall generation and a back-pressured, flushable handoff.

## Interface
- DATA_W, 16, register and operand width
- NREG, 8, number of architectural registers (power of two, ≥2)
- SEL_W, $clog2(NREG), register select width
- CNT_W, 2, scoreboard counter width; max in-flight writers per register = 2^CNT_W−1

- clk  in  1  clock; all state updates on rising edge
- rst  in  1  asynchronous, active-low reset
- in_valid  in  1  decoded instruction presented
- in_ready  out  1  instruction accepted this cycle when in_valid & in_ready
- in_rs1, in_rs2  in  SEL_W each  source selects
- in_rd  in  SEL_W  destination select
- in_rd_we  in  1  instruction writes in_rd
- in_is_load  in  1  result comes from memory
- in_imm  in  DATA_W  immediate, passed through
- wb_en, wb_sel, wb_data  in  1/SEL_W/DATA_W  writeback port; also retires one scoreboard entry
- sb_release, sb_release_sel  in  1/SEL_W  squashed downstream writer; retires one entry without writing
- ex_hit, ex_sel, ex_dv, ex_data  in  1/SEL_W/1/DATA_W  EX holds writer of ex_sel; ex_dv = result valid
- mem_hit, mem_sel, mem_dv, mem_data  in  same for MEM stage
- flush  in  1  kill output register contents and block acceptance this cycle
- out_valid  out  1  output register holds an instruction
- out_ready  in  1  execute consumes when out_valid & out_ready
- out_a, out_b, out_imm  out  DATA_W  resolved operands, immediate
- out_rd, out_rd_we, out_is_load  out  SEL_W/1/1  passed through
- stall  out  1  hazard stall asserted this cycle (debug/perf)

## Operation
- Register file: NREG×DATA_W flops, written on wb_en at clock edge; reads combinational.
- Operand resolution per source r, priority: ex_hit&ex_sel==r → ex_data; else mem_hit&mem_sel==r → mem_data; else wb_en&wb_sel==r → wb_data; else RF[r].
- Scoreboard cnt[r]: +1 on accepted instruction with in_rd_we for r. −1 for each of wb_en(wb_sel), sb_release(sb_release_sel), and flush of out register holding out_rd_we (out_rd). Multiple events on same r in one cycle sum algebraically. Underflow is a protocol error; the counter holds at 0.
- Hazard for source r (checked for rs1 and rs2 always): cnt[r]≠0 AND any of:
  - out_valid & out_rd_we & out_rd==r (producer not yet in EX);
  - matching EX writer with !ex_dv;
  - no EX/MEM match, and not wb_en&wb_sel==r.
- Structural stall: in_rd_we & cnt[in_rd]==2^CNT_W−1 (with no same-cycle retire of in_rd).
- stall = any hazard | structural stall.
- in_ready = !stall & !flush & (!out_valid | out_ready).
- Accept loads out_* from resolved operands; otherwise out register holds, or clears out_valid when consumed.

## Timing
- Reset (rst low, async): RF all 0; cnt all 0; out_valid 0; out_a/out_b/out_imm 0; out_rd 0; out_rd_we 0; out_is_load 0.
- Accept-to-out_valid latency: 1 cycle. WB-to-operand: 0 cycles (bypass).
- Accept and consume in the same cycle: new instruction replaces the old one; out_valid stays 1.
- flush: out_valid→0 next edge regardless of out_ready; no accept that cycle.
- Deassert of rst is registered on the next clk edge; asserting rst mid-stall discards all state.
- out_* stable while out_valid & !out_ready.

## Test plan
- Reset, then wb_en r3=0x1234 with a same-cycle accept reading rs1=3 → out_a=0x1234 one cycle later, cnt all 0.
- Issue writer r2 (ALU), then reader rs1=2 while the writer is still in out register → stall=1, in_ready=0. Next cycle ex_hit sel=2 dv=1 data=0xBEEF → accepted, out_a=0xBEEF.
- Load to r5 in EX (ex_dv=0), reader rs2=5 → stall one cycle. Then mem_hit sel=5 dv=1 data=0x00AA → out_b=0x00AA.
- Three writers to r1 with CNT_W=2 → fourth writer stalls until a wb_en sel=1. Same-cycle issue+retire on r1 keeps cnt=3.
- out_ready=0 for 4 cycles → out_* constant, in_ready=0. Then flush with out_rd_we=1, rd=6 → out_valid=0, cnt[6] decremented.
- Async rst pulse mid-stall → all outputs 0 immediately, cnt cleared, next instruction reads RF=0.

Source files
------------

// File: rtl/decode_operand_unit.sv
// Decode operand unit: RF with WB bypass, EX/MEM/WB forwarding, per-register writer scoreboard, hazard stall.
// Accept-to-out_valid is 1 cycle; in_ready drops on hazard, flush, or a held out register that execute is not taking.
module decode_operand_unit #(
  parameter int DATA_W = 16,
  parameter int NREG   = 8,
  parameter int SEL_W  = $clog2(NREG),
  parameter int CNT_W  = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [SEL_W-1:0]  in_rs1,
  input  logic [SEL_W-1:0]  in_rs2,
  input  logic [SEL_W-1:0]  in_rd,
  input  logic              in_rd_we,
  input  logic              in_is_load,
  input  logic [DATA_W-1:0] in_imm,
  input  logic              wb_en,
  input  logic [SEL_W-1:0]  wb_sel,
  input  logic [DATA_W-1:0] wb_data,
  input  logic              sb_release,
  input  logic [SEL_W-1:0]  sb_release_sel,
  input  logic              ex_hit,
  input  logic [SEL_W-1:0]  ex_sel,
  input  logic              ex_dv,
  input  logic [DATA_W-1:0] ex_data,
  input  logic              mem_hit,
  input  logic [SEL_W-1:0]  mem_sel,
  input  logic              mem_dv,
  input  logic [DATA_W-1:0] mem_data,
  input  logic              flush,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_a,
  output logic [DATA_W-1:0] out_b,
  output logic [DATA_W-1:0] out_imm,
  output logic [SEL_W-1:0]  out_rd,
  output logic              out_rd_we,
  output logic              out_is_load,
  output logic              stall
);

  localparam logic [CNT_W-1:0]   CNT_MAX  = {CNT_W{1'b1}};
  localparam logic [CNT_W+1:0]   CNT_MAXW = (CNT_W+2)'(CNT_MAX);

  logic [DATA_W-1:0]            r_rf [NREG];
  logic [NREG-1:0][CNT_W-1:0]   r_cnt;
  logic                         r_out_valid;
  logic [DATA_W-1:0]            r_out_a, r_out_b, r_out_imm;
  logic [SEL_W-1:0]             r_out_rd;
  logic                         r_out_rd_we, r_out_is_load;

  logic [1:0][SEL_W-1:0]        w_src;
  logic [1:0][DATA_W-1:0]       w_opnd;
  logic [1:0]                   w_ex_m, w_mem_m, w_wb_m, w_pend, w_haz;
  logic                         w_rd_retire, w_struct, w_stall, w_accept, w_kill_wr;
  logic [NREG-1:0][CNT_W-1:0]   w_cnt_nxt;
  logic [CNT_W+1:0]             w_up, w_dn, w_diff;

  assign w_src = {in_rs2, in_rs1};

  always_comb begin
    w_opnd  = '0;
    w_ex_m  = '0;
    w_mem_m = '0;
    w_wb_m  = '0;
    w_pend  = '0;
    w_haz   = '0;
    for (int i = 0; i < 2; i++) begin
      w_ex_m[i]  = ex_hit  && (ex_sel  == w_src[i]);
      w_mem_m[i] = mem_hit && (mem_sel == w_src[i]);
      w_wb_m[i]  = wb_en   && (wb_sel  == w_src[i]);
      w_pend[i]  = r_out_valid && r_out_rd_we && (r_out_rd == w_src[i]);
      if (w_ex_m[i])       w_opnd[i] = ex_data;
      else if (w_mem_m[i]) w_opnd[i] = mem_data;
      else if (w_wb_m[i])  w_opnd[i] = wb_data;
      else                 w_opnd[i] = r_rf[w_src[i]];
      // A pending writer with no forwardable value anywhere in the pipe blocks the read.
      w_haz[i] = (r_cnt[w_src[i]] != '0) &&
                 (w_pend[i] || (w_ex_m[i] && !ex_dv) ||
                  (!w_ex_m[i] && !w_mem_m[i] && !w_wb_m[i]));
    end
  end

  assign w_rd_retire = (wb_en && (wb_sel == in_rd)) || (sb_release && (sb_release_sel == in_rd));
  assign w_struct    = in_rd_we && (r_cnt[in_rd] == CNT_MAX) && !w_rd_retire;
  assign w_stall     = |w_haz || w_struct;
  assign stall       = w_stall;
  assign in_ready    = !w_stall && !flush && (!r_out_valid || out_ready);
  assign w_accept    = in_valid && in_ready;
  assign w_kill_wr   = flush && r_out_valid && r_out_rd_we;

  // Events on one register in the same cycle net out; underflow clamps at zero.
  always_comb begin
    w_cnt_nxt = r_cnt;
    w_up      = '0;
    w_dn      = '0;
    w_diff    = '0;
    for (int r = 0; r < NREG; r++) begin
      w_up = (CNT_W+2)'(r_cnt[r]) +
             (CNT_W+2)'(w_accept && in_rd_we && (in_rd == SEL_W'(r)));
      w_dn = (CNT_W+2)'(wb_en && (wb_sel == SEL_W'(r))) +
             (CNT_W+2)'(sb_release && (sb_release_sel == SEL_W'(r))) +
             (CNT_W+2)'(w_kill_wr && (r_out_rd == SEL_W'(r)));
      w_diff = (w_up > w_dn) ? (w_up - w_dn) : '0;
      w_cnt_nxt[r] = (w_diff > CNT_MAXW) ? CNT_MAX : w_diff[CNT_W-1:0];
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < NREG; i++) r_rf[i] <= '0;
      r_cnt <= '0;
    end else begin
      if (wb_en) r_rf[wb_sel] <= wb_data;
      r_cnt <= w_cnt_nxt;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_out_valid   <= 1'b0;
      r_out_a       <= '0;
      r_out_b       <= '0;
      r_out_imm     <= '0;
      r_out_rd      <= '0;
      r_out_rd_we   <= 1'b0;
      r_out_is_load <= 1'b0;
    end else if (flush) begin
      r_out_valid   <= 1'b0;
    end else if (w_accept) begin
      r_out_valid   <= 1'b1;
      r_out_a       <= w_opnd[0];
      r_out_b       <= w_opnd[1];
      r_out_imm     <= in_imm;
      r_out_rd      <= in_rd;
      r_out_rd_we   <= in_rd_we;
      r_out_is_load <= in_is_load;
    end else if (out_ready) begin
      r_out_valid   <= 1'b0;
    end
  end

  assign out_valid   = r_out_valid;
  assign out_a       = r_out_a;
  assign out_b       = r_out_b;
  assign out_imm     = r_out_imm;
  assign out_rd      = r_out_rd;
  assign out_rd_we   = r_out_rd_we;
  assign out_is_load = r_out_is_load;

  logic w_unused;
  assign w_unused = mem_dv;

endmodule

// File: tb/tb_decode_operand_unit.sv
// Scoreboard bench for decode_operand_unit: expected out_* records queued at accept, popped one edge later.
module tb_decode_operand_unit;
  localparam int DW = 16;
  localparam int SW = 3;

  typedef struct packed {
    logic [DW-1:0] a;
    logic [DW-1:0] b;
    logic [DW-1:0] imm;
    logic [SW-1:0] rd;
    logic          we;
    logic          ld;
  } exp_t;

  logic clk, rst;
  logic in_valid, in_ready, in_rd_we, in_is_load;
  logic [SW-1:0] in_rs1, in_rs2, in_rd;
  logic [DW-1:0] in_imm;
  logic wb_en, sb_release, ex_hit, ex_dv, mem_hit, mem_dv, flush;
  logic [SW-1:0] wb_sel, sb_release_sel, ex_sel, mem_sel;
  logic [DW-1:0] wb_data, ex_data, mem_data;
  logic out_valid, out_ready, out_rd_we, out_is_load, stall;
  logic [DW-1:0] out_a, out_b, out_imm;
  logic [SW-1:0] out_rd;

  int n_checks;
  int n_err;
  exp_t q[$];
  exp_t e;

  decode_operand_unit #(.DATA_W(DW), .NREG(8), .SEL_W(SW), .CNT_W(2)) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_rs1(in_rs1), .in_rs2(in_rs2), .in_rd(in_rd), .in_rd_we(in_rd_we),
    .in_is_load(in_is_load), .in_imm(in_imm),
    .wb_en(wb_en), .wb_sel(wb_sel), .wb_data(wb_data),
    .sb_release(sb_release), .sb_release_sel(sb_release_sel),
    .ex_hit(ex_hit), .ex_sel(ex_sel), .ex_dv(ex_dv), .ex_data(ex_data),
    .mem_hit(mem_hit), .mem_sel(mem_sel), .mem_dv(mem_dv), .mem_data(mem_data),
    .flush(flush),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_a(out_a), .out_b(out_b), .out_imm(out_imm),
    .out_rd(out_rd), .out_rd_we(out_rd_we), .out_is_load(out_is_load),
    .stall(stall)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic exp_t obs();
    return '{a: out_a, b: out_b, imm: out_imm, rd: out_rd, we: out_rd_we, ld: out_is_load};
  endfunction

  function automatic exp_t mk(input logic [DW-1:0] a, input logic [DW-1:0] b, input logic [DW-1:0] imm,
                              input logic [SW-1:0] rd, input logic we, input logic ld);
    return '{a: a, b: b, imm: imm, rd: rd, we: we, ld: ld};
  endfunction

  task automatic idle();
    in_valid = 0; in_rs1 = 0; in_rs2 = 0; in_rd = 0; in_rd_we = 0; in_is_load = 0; in_imm = 0;
    wb_en = 0; wb_sel = 0; wb_data = 0; sb_release = 0; sb_release_sel = 0;
    ex_hit = 0; ex_sel = 0; ex_dv = 0; ex_data = 0;
    mem_hit = 0; mem_sel = 0; mem_dv = 0; mem_data = 0;
    flush = 0; out_ready = 1;
  endtask

  task automatic drive_instr(input logic [SW-1:0] rs1, input logic [SW-1:0] rs2, input logic [SW-1:0] rd,
                             input logic we, input logic ld, input logic [DW-1:0] imm);
    in_valid = 1; in_rs1 = rs1; in_rs2 = rs2; in_rd = rd; in_rd_we = we; in_is_load = ld; in_imm = imm;
  endtask

  task automatic next_edge();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 0;
    idle();
    repeat (2) @(posedge clk);
    #1;
    n_checks++;
    if ({out_valid, obs(), stall} !== '0) begin
      n_err++; $display("FAIL reset_outputs: got v=%0b %h stall=%0b want all 0", out_valid, obs(), stall);
    end
    n_checks++;
    if (dut.r_cnt !== '0) begin n_err++; $display("FAIL reset_cnt: got %h want 0", dut.r_cnt); end
    rst = 1;
    next_edge();
  endtask

  task automatic test_wb_bypass();
    drive_instr(3, 0, 0, 0, 0, 16'h0011);
    wb_en = 1; wb_sel = 3; wb_data = 16'h1234;
    @(negedge clk);
    n_checks++;
    if (in_ready !== 1'b1) begin n_err++; $display("FAIL bypass_ready: got %0b want 1", in_ready); end
    q.push_back(mk(16'h1234, 16'h0000, 16'h0011, 0, 0, 0));
    next_edge();
    idle();
    drive_instr(0, 3, 0, 0, 1, 16'h0012);
    if (q.size() != 0) e = q.pop_front(); else e = 'x;
    n_checks++;
    if ({out_valid, obs()} !== {1'b1, e}) begin
      n_err++; $display("FAIL bypass_out: got v=%0b %h want %h", out_valid, obs(), e);
    end
    n_checks++;
    if (dut.r_cnt !== '0) begin n_err++; $display("FAIL bypass_cnt: got %h want 0", dut.r_cnt); end
    q.push_back(mk(16'h0000, 16'h1234, 16'h0012, 0, 0, 1));
    next_edge();
    idle();
    if (q.size() != 0) e = q.pop_front(); else e = 'x;
    n_checks++;
    if ({out_valid, obs()} !== {1'b1, e}) begin
      n_err++; $display("FAIL rf_read_out: got v=%0b %h want %h", out_valid, obs(), e);
    end
    next_edge();
  endtask

  task automatic test_ex_forward();
    drive_instr(0, 0, 2, 1, 0, 16'h0022);
    q.push_back(mk(0, 0, 16'h0022, 2, 1, 0));
    next_edge();
    if (q.size() != 0) e = q.pop_front(); else e = 'x;
    n_checks++;
    if ({out_valid, obs()} !== {1'b1, e}) begin
      n_err++; $display("FAIL alu_writer_out: got v=%0b %h want %h", out_valid, obs(), e);
    end
    n_checks++;
    if (dut.r_cnt[2] !== 2'd1) begin n_err++; $display("FAIL alu_cnt2: got %0d want 1", dut.r_cnt[2]); end
    drive_instr(2, 0, 0, 0, 0, 16'h0033);
    @(negedge clk);
    n_checks++;
    if ({stall, in_ready} !== 2'b10) begin
      n_err++; $display("FAIL raw_stall: got stall=%0b in_ready=%0b want 1/0", stall, in_ready);
    end
    next_edge();
    ex_hit = 1; ex_sel = 2; ex_dv = 1; ex_data = 16'hBEEF;
    @(negedge clk);
    n_checks++;
    if ({stall, in_ready} !== 2'b01) begin
      n_err++; $display("FAIL ex_fwd_ready: got stall=%0b in_ready=%0b want 0/1", stall, in_ready);
    end
    q.push_back(mk(16'hBEEF, 0, 16'h0033, 0, 0, 0));
    next_edge();
    idle();
    wb_en = 1; wb_sel = 2; wb_data = 16'hBEEF;
    if (q.size() != 0) e = q.pop_front(); else e = 'x;
    n_checks++;
    if ({out_valid, obs()} !== {1'b1, e}) begin
      n_err++; $display("FAIL ex_fwd_out: got v=%0b %h want %h", out_valid, obs(), e);
    end
    next_edge();
    idle();
    n_checks++;
    if (dut.r_cnt[2] !== 2'd0) begin n_err++; $display("FAIL alu_cnt2_retired: got %0d want 0", dut.r_cnt[2]); end
  endtask

  task automatic test_load_use();
    drive_instr(0, 0, 5, 1, 1, 16'h0055);
    q.push_back(mk(0, 0, 16'h0055, 5, 1, 1));
    next_edge();
    idle();
    if (q.size() != 0) e = q.pop_front(); else e = 'x;
    n_checks++;
    if ({out_valid, obs()} !== {1'b1, e}) begin
      n_err++; $display("FAIL load_out: got v=%0b %h want %h", out_valid, obs(), e);
    end
    next_edge();
    drive_instr(0, 5, 0, 0, 0, 16'h0066);
    ex_hit = 1; ex_sel = 5; ex_dv = 0; ex_data = 16'hDEAD;
    @(negedge clk);
    n_checks++;
    if ({stall, in_ready} !== 2'b10) begin
      n_err++; $display("FAIL load_use_stall: got stall=%0b in_ready=%0b want 1/0", stall, in_ready);
    end
    next_edge();
    n_checks++;
    if (out_valid !== 1'b0) begin n_err++; $display("FAIL load_use_no_accept: got %0b want 0", out_valid); end
    ex_hit = 0; ex_dv = 0;
    mem_hit = 1; mem_sel = 5; mem_dv = 1; mem_data = 16'h00AA;
    @(negedge clk);
    n_checks++;
    if (in_ready !== 1'b1) begin n_err++; $display("FAIL mem_fwd_ready: got %0b want 1", in_ready); end
    q.push_back(mk(0, 16'h00AA, 16'h0066, 0, 0, 0));
    next_edge();
    idle();
    wb_en = 1; wb_sel = 5; wb_data = 16'h00AA;
    if (q.size() != 0) e = q.pop_front(); else e = 'x;
    n_checks++;
    if ({out_valid, obs()} !== {1'b1, e}) begin
      n_err++; $display("FAIL mem_fwd_out: got v=%0b %h want %h", out_valid, obs(), e);
    end
    next_edge();
    idle();
  endtask

  task automatic test_structural();
    for (int k = 0; k < 3; k++) begin
      drive_instr(0, 0, 1, 1, 0, 16'(k + 1));
      @(negedge clk);
      n_checks++;
      if (in_ready !== 1'b1) begin n_err++; $display("FAIL writer%0d_ready: got %0b want 1", k, in_ready); end
      q.push_back(mk(0, 0, 16'(k + 1), 1, 1, 0));
      next_edge();
      if (q.size() != 0) e = q.pop_front(); else e = 'x;
      n_checks++;
      if ({out_valid, obs()} !== {1'b1, e}) begin
        n_err++; $display("FAIL writer%0d_out: got v=%0b %h want %h", k, out_valid, obs(), e);
      end
    end
    n_checks++;
    if (dut.r_cnt[1] !== 2'd3) begin n_err++; $display("FAIL cnt1_full: got %0d want 3", dut.r_cnt[1]); end
    drive_instr(0, 0, 1, 1, 0, 16'h0004);
    @(negedge clk);
    n_checks++;
    if ({stall, in_ready} !== 2'b10) begin
      n_err++; $display("FAIL struct_stall: got stall=%0b in_ready=%0b want 1/0", stall, in_ready);
    end
    next_edge();
    wb_en = 1; wb_sel = 1; wb_data = 16'h0101;
    @(negedge clk);
    n_checks++;
    if ({stall, in_ready} !== 2'b01) begin
      n_err++; $display("FAIL struct_retire_ready: got stall=%0b in_ready=%0b want 0/1", stall, in_ready);
    end
    q.push_back(mk(0, 0, 16'h0004, 1, 1, 0));
    next_edge();
    idle();
    if (q.size() != 0) e = q.pop_front(); else e = 'x;
    n_checks++;
    if ({out_valid, obs()} !== {1'b1, e}) begin
      n_err++; $display("FAIL writer3_out: got v=%0b %h want %h", out_valid, obs(), e);
    end
    n_checks++;
    if (dut.r_cnt[1] !== 2'd3) begin n_err++; $display("FAIL cnt1_issue_retire: got %0d want 3", dut.r_cnt[1]); end
    wb_en = 1; wb_sel = 1; wb_data = 16'h0102;
    next_edge();
    idle();
    wb_en = 1; wb_sel = 1; wb_data = 16'h0103;
    next_edge();
    idle();
    sb_release = 1; sb_release_sel = 1;
    next_edge();
    idle();
    n_checks++;
    if (dut.r_cnt[1] !== 2'd0) begin n_err++; $display("FAIL cnt1_drained: got %0d want 0", dut.r_cnt[1]); end
  endtask

  task automatic test_back_to_back();
    for (int k = 0; k < 3; k++) begin
      drive_instr(3, 5, 0, 0, 0, 16'(16'h0100 + k));
      @(negedge clk);
      n_checks++;
      if (in_ready !== 1'b1) begin n_err++; $display("FAIL b2b%0d_ready: got %0b want 1", k, in_ready); end
      q.push_back(mk(16'h1234, 16'h00AA, 16'(16'h0100 + k), 0, 0, 0));
      next_edge();
      if (q.size() != 0) e = q.pop_front(); else e = 'x;
      n_checks++;
      if ({out_valid, obs()} !== {1'b1, e}) begin
        n_err++; $display("FAIL b2b%0d_out: got v=%0b %h want %h", k, out_valid, obs(), e);
      end
    end
    idle();
    next_edge();
  endtask

  task automatic test_backpressure_flush();
    exp_t held;
    out_ready = 0;
    drive_instr(3, 2, 6, 1, 0, 16'h0066);
    held = mk(16'h1234, 16'hBEEF, 16'h0066, 6, 1, 0);
    q.push_back(held);
    next_edge();
    drive_instr(0, 0, 0, 0, 0, 16'h0077);
    if (q.size() != 0) e = q.pop_front(); else e = 'x;
    n_checks++;
    if ({out_valid, obs()} !== {1'b1, e}) begin
      n_err++; $display("FAIL bp_load_out: got v=%0b %h want %h", out_valid, obs(), e);
    end
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      n_checks++;
      if ({out_valid, obs(), in_ready} !== {1'b1, held, 1'b0}) begin
        n_err++; $display("FAIL bp_hold%0d: got v=%0b %h rdy=%0b want v=1 %h rdy=0", k, out_valid, obs(), in_ready, held);
      end
      next_edge();
    end
    n_checks++;
    if (dut.r_cnt[6] !== 2'd1) begin n_err++; $display("FAIL cnt6_pending: got %0d want 1", dut.r_cnt[6]); end
    flush = 1;
    @(negedge clk);
    n_checks++;
    if (in_ready !== 1'b0) begin n_err++; $display("FAIL flush_blocks: got %0b want 0", in_ready); end
    next_edge();
    idle();
    n_checks++;
    if (out_valid !== 1'b0) begin n_err++; $display("FAIL flush_valid: got %0b want 0", out_valid); end
    n_checks++;
    if (dut.r_cnt[6] !== 2'd0) begin n_err++; $display("FAIL cnt6_flushed: got %0d want 0", dut.r_cnt[6]); end
  endtask

  task automatic test_async_reset();
    out_ready = 0;
    drive_instr(0, 0, 4, 1, 0, 16'h0044);
    q.push_back(mk(0, 0, 16'h0044, 4, 1, 0));
    next_edge();
    drive_instr(4, 0, 0, 0, 0, 16'h0045);
    if (q.size() != 0) e = q.pop_front(); else e = 'x;
    n_checks++;
    if ({out_valid, obs()} !== {1'b1, e}) begin
      n_err++; $display("FAIL ar_writer_out: got v=%0b %h want %h", out_valid, obs(), e);
    end
    @(negedge clk);
    n_checks++;
    if (stall !== 1'b1) begin n_err++; $display("FAIL ar_pre_stall: got %0b want 1", stall); end
    #2 rst = 0;
    #1;
    n_checks++;
    if ({out_valid, obs(), stall} !== '0) begin
      n_err++; $display("FAIL ar_outputs: got v=%0b %h stall=%0b want all 0", out_valid, obs(), stall);
    end
    n_checks++;
    if (dut.r_cnt !== '0) begin n_err++; $display("FAIL ar_cnt: got %h want 0", dut.r_cnt); end
    next_edge();
    rst = 1;
    idle();
    drive_instr(3, 5, 0, 0, 0, 16'h0046);
    @(negedge clk);
    n_checks++;
    if (in_ready !== 1'b1) begin n_err++; $display("FAIL ar_ready: got %0b want 1", in_ready); end
    q.push_back(mk(0, 0, 16'h0046, 0, 0, 0));
    next_edge();
    idle();
    if (q.size() != 0) e = q.pop_front(); else e = 'x;
    n_checks++;
    if ({out_valid, obs()} !== {1'b1, e}) begin
      n_err++; $display("FAIL ar_rf_cleared: got v=%0b %h want %h", out_valid, obs(), e);
    end
    next_edge();
  endtask

  initial begin
    n_checks = 0;
    n_err = 0;
    rst = 0;
    idle();
    test_reset();
    test_wb_bypass();
    test_ex_forward();
    test_load_use();
    test_structural();
    test_back_to_back();
    test_backpressure_flush();
    test_async_reset();
    n_checks++;
    if (q.size() != 0) begin n_err++; $display("FAIL scoreboard_drained: got %0d left want 0", q.size()); end
    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
